sync_updown_counter: RTL and testbench

SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

---
 rtl/sync_counter_pkg.sv | 18 +
 rtl/tick_gen.sv | 52 +++++
 rtl/sync_updown_counter.sv | 102 ++++++++++
 tb/tb_sync_updown_counter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_counter_pkg
//  Description : Shared constants for the synchronous up/down counter and
//                its prescaler (count-mode selectors, prescaler width).
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_counter_pkg;

    // Boundary behaviour selectors for the SATURATE parameter
    localparam int MODE_WRAP  = 0;
    localparam int MODE_SAT   = 1;

    // Width of the prescaler counter; bounds PRESCALE to 1..65535
    localparam int PRESCALE_W = 16;

endpackage : sync_counter_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler. Counts enabled cycles and raises a one-cycle tick
//                on every PRESCALE-th enabled cycle. clr restarts the period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import sync_counter_pkg::*;
#(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] c_last = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // A clear on the same edge wins over the tick so a load never also steps
    assign tick = en && !clr && (cnt_q == c_last);

    // Next prescaler count: clear, restart after a tick, advance, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == c_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Prescaler register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/sync_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sync_updown_counter
//  Description : Modulo-N synchronous up/down counter with parallel load,
//                optional saturation, prescaled stepping, a combinational
//                terminal-count flag and a registered wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_updown_counter
    import sync_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = MODE_WRAP,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Reject parameter sets that cannot be represented or make no sense
    if ((longint'(MODULUS) > (longint'(1) << WIDTH)) || (MODULUS < 2) ||
        (PRESCALE < 1) || (PRESCALE > 65535)) begin : g_param_check
        $error("sync_updown_counter: illegal MODULUS/WIDTH/PRESCALE combination");
    end

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             w_tick;
    logic             w_step;

    // PRESCALE=1 needs no counter: every enabled cycle is a tick
    if (PRESCALE == 1) begin : g_no_prescale
        assign w_tick = en;
    end else begin : g_prescale
        tick_gen #(
            .PRESCALE (PRESCALE)
        ) u_tick_gen (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .clr   (load),
            .tick  (w_tick)
        );
    end

    assign w_step = w_tick && !load;

    // Terminal count tracks the bound in the current direction
    assign tc   = up_dn ? (count_q == c_max) : (count_q == '0);
    assign q    = count_q;
    assign wrap = wrap_q;

    // Next count and wrap flag: load (clamped) > step > hold
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > c_max) ? c_max : load_val;
        end else if (w_step) begin
            // Any step taken at the bound reports a wrap, saturating or not
            wrap_d = tc;
            if (up_dn) begin
                if (count_q == c_max) begin
                    count_d = (SATURATE == MODE_SAT) ? count_q : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = (SATURATE == MODE_SAT) ? count_q : c_max;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Count and wrap registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule : sync_updown_counter
`default_nettype wire

// File: tb/tb_sync_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_updown_counter
//  Description : Self-checking bench. Three instances (wrap, saturate,
//                prescale-by-3) share stimulus; each is tracked by an
//                arithmetic reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_updown_counter;

    localparam int N_DUT = 3;
    localparam int MOD   = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] dq  [N_DUT];
    logic       dtc [N_DUT];
    logic       dw  [N_DUT];

    int c_sat [N_DUT] = '{0, 1, 0};
    int c_pre [N_DUT] = '{1, 1, 3};

    // Reference model state per instance
    int mq [N_DUT];
    int mp [N_DUT];
    int mw [N_DUT];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       r;
        logic       e;
        logic       u;
        logic       l;
        logic [3:0] lv;
        int         eq;
        int         ew;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(4), .MODULUS(MOD), .SATURATE(0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(dq[0]), .tc(dtc[0]), .wrap(dw[0]));

    sync_updown_counter #(.WIDTH(4), .MODULUS(MOD), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(dq[1]), .tc(dtc[1]), .wrap(dw[1]));

    sync_updown_counter #(.WIDTH(4), .MODULUS(MOD), .SATURATE(0), .PRESCALE(3)) u_pre (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(dq[2]), .tc(dtc[2]), .wrap(dw[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv);
        reset    = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = lv;
    endtask

    // Counter behaviour from first principles: integer count, integer
    // prescale phase, out-of-range results folded back or clamped.
    task automatic model_edge(input int k);
        int nq;
        if (reset) begin
            mq[k] = 0; mp[k] = 0; mw[k] = 0;
        end else if (load) begin
            mq[k] = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
            mp[k] = 0; mw[k] = 0;
        end else if (en) begin
            mw[k] = 0;
            mp[k] = mp[k] + 1;
            if (mp[k] == c_pre[k]) begin
                mp[k] = 0;
                nq = up_dn ? mq[k] + 1 : mq[k] - 1;
                if (nq >= MOD) begin
                    mw[k] = 1;
                    nq = (c_sat[k] != 0) ? MOD - 1 : 0;
                end else if (nq < 0) begin
                    mw[k] = 1;
                    nq = (c_sat[k] != 0) ? 0 : MOD - 1;
                end
                mq[k] = nq;
            end
        end else begin
            mw[k] = 0;
        end
    endtask

    // One clock: advance models with the applied inputs, then compare all
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < N_DUT; k++) model_edge(k);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("model_q[%0d]", k), int'(dq[k]), mq[k]);
            chk($sformatf("model_wrap[%0d]", k), int'(dw[k]), mw[k]);
            chk($sformatf("model_tc[%0d]", k), int'(dtc[k]),
                up_dn ? int'(mq[k] == MOD - 1) : int'(mq[k] == 0));
        end
    endtask

    task automatic add(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input int eq, input int ew);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv; v.eq = eq; v.ew = ew;
        vecs.push_back(v);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < N_DUT; k++) begin
            mq[k] = 0; mp[k] = 0; mw[k] = 0;
        end

        // Directed vectors for the wrapping, unprescaled instance
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) add(0, 1, 1, 0, 0, i % 10, int'(i == 10));
        add(0, 0, 1, 1, 4'd3, 3, 0);
        add(0, 1, 0, 0, 0, 2, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9, 1);
        add(0, 1, 0, 0, 0, 8, 0);
        add(0, 1, 1, 1, 4'd14, 9, 0);
        add(0, 1, 1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].l, vecs[i].lv);
            cycle();
            chk($sformatf("vec%0d_q", i), int'(dq[0]), vecs[i].eq);
            chk($sformatf("vec%0d_wrap", i), int'(dw[0]), vecs[i].ew);
        end

        // Saturation: from 8 counting up holds at 9 and pulses wrap per step
        drive(0, 0, 1, 1, 4'd8);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 4'd0);
            cycle();
            chk($sformatf("sat_q%0d", i), int'(dq[1]), 9);
            chk($sformatf("sat_wrap%0d", i), int'(dw[1]), (i == 0) ? 0 : 1);
        end

        // Prescale by 3: one step per three enabled cycles
        drive(1, 0, 1, 0, 4'd0);
        cycle();
        for (int i = 1; i <= 9; i++) begin
            drive(0, 1, 1, 0, 4'd0);
            cycle();
            chk($sformatf("pre_q%0d", i), int'(dq[2]), i / 3);
        end
        // Dropping en for two cycles stretches the period by two
        drive(0, 1, 1, 0, 4'd0); cycle(); chk("pre_gap_a", int'(dq[2]), 3);
        drive(0, 0, 1, 0, 4'd0); cycle(); chk("pre_gap_b", int'(dq[2]), 3);
        drive(0, 0, 1, 0, 4'd0); cycle(); chk("pre_gap_c", int'(dq[2]), 3);
        drive(0, 1, 1, 0, 4'd0); cycle(); chk("pre_gap_d", int'(dq[2]), 3);
        drive(0, 1, 1, 0, 4'd0); cycle(); chk("pre_gap_e", int'(dq[2]), 4);

        // Reset mid-count with load active: reset wins, prescale restarts
        drive(0, 0, 1, 1, 4'd7); cycle();
        drive(0, 1, 1, 0, 4'd0); cycle();
        chk("rst_pre_q", int'(dq[2]), 7);
        drive(1, 1, 0, 1, 4'd5); cycle();
        chk("rst_q", int'(dq[2]), 0);
        chk("rst_wrap", int'(dw[2]), 0);
        chk("rst_tc_down", int'(dtc[2]), 1);
        drive(0, 1, 1, 0, 4'd0); cycle(); chk("rel_q1", int'(dq[2]), 0);
        chk("rel_tc_up", int'(dtc[2]), 0);
        cycle(); chk("rel_q2", int'(dq[2]), 0);
        cycle(); chk("rel_q3", int'(dq[2]), 1);

        // Randomised traffic against the reference models
        for (int i = 0; i < 3000; i++) begin
            drive(logic'($urandom_range(0, 49) == 0),
                  logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_updown_counter
`default_nettype wire
